// File: rtl/pri_icache_ctrl_slave.sv
// Cache-side endpoint of the private icache control bus: sequences bypass switches and flushes
// against cache idle/flush-done status and keeps the fetch performance counters.
module pri_icache_ctrl_slave #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter bit          SATURATE  = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 bypass_req_i,
    output logic                 bypass_ack_o,
    input  logic                 flush_req_i,
    output logic                 flush_ack_o,

    input  logic                 ctrl_clear_regs_i,
    input  logic                 ctrl_enable_regs_i,
    output logic [CNT_WIDTH-1:0] ctrl_hit_count_o,
    output logic [CNT_WIDTH-1:0] ctrl_trans_count_o,
    output logic [CNT_WIDTH-1:0] ctrl_miss_count_o,

    input  logic                 cache_idle_i,
    output logic                 cache_bypass_o,
    output logic                 cache_flush_o,
    input  logic                 cache_flush_done_i,

    input  logic                 fetch_trans_i,
    input  logic                 fetch_hit_i,
    input  logic                 fetch_miss_i
);

    typedef enum logic [2:0] {
        StIdle,
        StBypDrain,
        StFlushDrain,
        StFlushWait,
        StFlushAck
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    state_e state_q, state_d;

    logic cache_bypass_q, cache_bypass_d;
    logic bypass_ack_q, bypass_ack_d;
    logic flush_ack_q, flush_ack_d;
    logic cache_flush_q, cache_flush_d;

    logic [CNT_WIDTH-1:0] trans_cnt_q, trans_cnt_d;
    logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

    logic trans_inc, hit_inc, miss_inc;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                // A pending flush takes priority over a bypass change.
                if (flush_req_i && !flush_ack_q) begin
                    state_d = StFlushDrain;
                end else if (bypass_req_i != cache_bypass_q) begin
                    state_d = StBypDrain;
                end
            end
            StBypDrain: begin
                if (cache_idle_i) state_d = StIdle;
            end
            StFlushDrain: begin
                if (cache_idle_i) state_d = StFlushWait;
            end
            StFlushWait: begin
                if (cache_flush_done_i) state_d = StFlushAck;
            end
            StFlushAck: begin
                if (!flush_req_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cache_bypass_d = cache_bypass_q;
        flush_ack_d    = flush_ack_q;
        cache_flush_d  = 1'b0;
        // The acknowledge trails the applied bypass select by exactly one cycle.
        bypass_ack_d   = cache_bypass_q;
        unique case (state_q)
            StBypDrain: begin
                if (cache_idle_i) cache_bypass_d = bypass_req_i;
            end
            StFlushDrain: begin
                if (cache_idle_i) cache_flush_d = 1'b1;
            end
            StFlushWait: begin
                if (cache_flush_done_i) flush_ack_d = 1'b1;
            end
            StFlushAck: begin
                if (!flush_req_i) flush_ack_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cache_bypass_q <= 1'b0;
            bypass_ack_q   <= 1'b0;
            flush_ack_q    <= 1'b0;
            cache_flush_q  <= 1'b0;
        end else begin
            cache_bypass_q <= cache_bypass_d;
            bypass_ack_q   <= bypass_ack_d;
            flush_ack_q    <= flush_ack_d;
            cache_flush_q  <= cache_flush_d;
        end
    end

    assign cache_bypass_o = cache_bypass_q;
    assign bypass_ack_o   = bypass_ack_q;
    assign flush_ack_o    = flush_ack_q;
    assign cache_flush_o  = cache_flush_q;

    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
    function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cnt,
                                                      input logic                 inc);
        logic [CNT_WIDTH-1:0] res;
        res = cnt;
        if (inc) begin
            if (SATURATE && (&cnt)) begin
                res = cnt;
            end else begin
                res = cnt + CntOne;
            end
        end
        return res;
    endfunction

    // Hit/miss reflect tag lookups, which do not happen while the cache is bypassed.
    assign trans_inc = ctrl_enable_regs_i & fetch_trans_i;
    assign hit_inc   = ctrl_enable_regs_i & fetch_hit_i & ~cache_bypass_q;
    assign miss_inc  = ctrl_enable_regs_i & fetch_miss_i & ~cache_bypass_q;

    always_comb begin
        trans_cnt_d = cnt_next(trans_cnt_q, trans_inc);
        hit_cnt_d   = cnt_next(hit_cnt_q, hit_inc);
        miss_cnt_d  = cnt_next(miss_cnt_q, miss_inc);
        if (ctrl_clear_regs_i) begin
            trans_cnt_d = '0;
            hit_cnt_d   = '0;
            miss_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trans_cnt_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            trans_cnt_q <= trans_cnt_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign ctrl_trans_count_o = trans_cnt_q;
    assign ctrl_hit_count_o   = hit_cnt_q;
    assign ctrl_miss_count_o  = miss_cnt_q;

endmodule

// File: tb/tb_pri_icache_ctrl_slave.sv
// Directed bench for pri_icache_ctrl_slave; narrow-counter instances reach the all-ones boundary
// in a few hundred cycles instead of 2^32.
module tb_pri_icache_ctrl_slave;

    logic clk = 1'b0;
    logic rst_n;
    logic bypass_req, flush_req, clear_regs, enable_regs;
    logic cache_idle, flush_done, f_trans, f_hit, f_miss;

    logic        bypass_ack, flush_ack, cache_bypass, cache_flush;
    logic [31:0] hit_cnt, trans_cnt, miss_cnt;

    logic       s_bypass_ack, s_flush_ack, s_cache_bypass, s_cache_flush;
    logic [7:0] s_hit, s_trans, s_miss;
    logic       w_bypass_ack, w_flush_ack, w_cache_bypass, w_cache_flush;
    logic [7:0] w_hit, w_trans, w_miss;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pri_icache_ctrl_slave #(.CNT_WIDTH(32), .SATURATE(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .bypass_req_i(bypass_req), .bypass_ack_o(bypass_ack),
        .flush_req_i(flush_req), .flush_ack_o(flush_ack),
        .ctrl_clear_regs_i(clear_regs), .ctrl_enable_regs_i(enable_regs),
        .ctrl_hit_count_o(hit_cnt), .ctrl_trans_count_o(trans_cnt),
        .ctrl_miss_count_o(miss_cnt),
        .cache_idle_i(cache_idle), .cache_bypass_o(cache_bypass),
        .cache_flush_o(cache_flush), .cache_flush_done_i(flush_done),
        .fetch_trans_i(f_trans), .fetch_hit_i(f_hit), .fetch_miss_i(f_miss)
    );

    pri_icache_ctrl_slave #(.CNT_WIDTH(8), .SATURATE(1'b1)) u_sat (
        .clk_i(clk), .rst_ni(rst_n),
        .bypass_req_i(bypass_req), .bypass_ack_o(s_bypass_ack),
        .flush_req_i(flush_req), .flush_ack_o(s_flush_ack),
        .ctrl_clear_regs_i(clear_regs), .ctrl_enable_regs_i(enable_regs),
        .ctrl_hit_count_o(s_hit), .ctrl_trans_count_o(s_trans), .ctrl_miss_count_o(s_miss),
        .cache_idle_i(cache_idle), .cache_bypass_o(s_cache_bypass),
        .cache_flush_o(s_cache_flush), .cache_flush_done_i(flush_done),
        .fetch_trans_i(f_trans), .fetch_hit_i(f_hit), .fetch_miss_i(f_miss)
    );

    pri_icache_ctrl_slave #(.CNT_WIDTH(8), .SATURATE(1'b0)) u_wrap (
        .clk_i(clk), .rst_ni(rst_n),
        .bypass_req_i(bypass_req), .bypass_ack_o(w_bypass_ack),
        .flush_req_i(flush_req), .flush_ack_o(w_flush_ack),
        .ctrl_clear_regs_i(clear_regs), .ctrl_enable_regs_i(enable_regs),
        .ctrl_hit_count_o(w_hit), .ctrl_trans_count_o(w_trans), .ctrl_miss_count_o(w_miss),
        .cache_idle_i(cache_idle), .cache_bypass_o(w_cache_bypass),
        .cache_flush_o(w_cache_flush), .cache_flush_done_i(flush_done),
        .fetch_trans_i(f_trans), .fetch_hit_i(f_hit), .fetch_miss_i(f_miss)
    );

    // Advance n rising edges; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_byp"}, 32'(cache_bypass), 32'h0);
        chk({tag, "_bypack"}, 32'(bypass_ack), 32'h0);
        chk({tag, "_flush"}, 32'(cache_flush), 32'h0);
        chk({tag, "_flack"}, 32'(flush_ack), 32'h0);
        chk({tag, "_trans"}, trans_cnt, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        bypass_req = 1'b0; flush_req = 1'b0; clear_regs = 1'b0; enable_regs = 1'b0;
        cache_idle = 1'b1; flush_done = 1'b0; f_trans = 1'b0; f_hit = 1'b0; f_miss = 1'b0;
        tick(2);
        chk_outs_zero("reset");
        chk("reset_hit", hit_cnt, 32'h0);
        chk("reset_miss", miss_cnt, 32'h0);
        rst_n = 1'b1;
        tick(1);

        // Bypass switch held off by a busy cache
        bypass_req = 1'b1; cache_idle = 1'b0;
        tick(5);
        chk("byp_wait_sel", 32'(cache_bypass), 32'h0);
        chk("byp_wait_ack", 32'(bypass_ack), 32'h0);
        cache_idle = 1'b1;
        tick(1);
        chk("byp_on_sel", 32'(cache_bypass), 32'h1);
        chk("byp_on_ack_lag", 32'(bypass_ack), 32'h0);
        tick(1);
        chk("byp_on_ack", 32'(bypass_ack), 32'h1);
        bypass_req = 1'b0; cache_idle = 1'b0;
        tick(3);
        chk("byp_off_wait", 32'(cache_bypass), 32'h1);
        cache_idle = 1'b1;
        tick(1);
        chk("byp_off_sel", 32'(cache_bypass), 32'h0);
        chk("byp_off_ack_lag", 32'(bypass_ack), 32'h1);
        tick(1);
        chk("byp_off_ack", 32'(bypass_ack), 32'h0);

        // Flush with done returned two cycles after the command
        flush_req = 1'b1;
        tick(1);
        chk("fl_drain_cmd", 32'(cache_flush), 32'h0);
        tick(1);
        chk("fl_cmd", 32'(cache_flush), 32'h1);
        tick(1);
        chk("fl_cmd_1cyc", 32'(cache_flush), 32'h0);
        tick(1);
        chk("fl_wait_ack", 32'(flush_ack), 32'h0);
        flush_done = 1'b1;
        tick(1);
        flush_done = 1'b0;
        chk("fl_ack", 32'(flush_ack), 32'h1);
        tick(2);
        chk("fl_ack_hold", 32'(flush_ack), 32'h1);
        chk("fl_no_recmd", 32'(cache_flush), 32'h0);
        flush_req = 1'b0;
        tick(1);
        chk("fl_ack_drop", 32'(flush_ack), 32'h0);
        flush_done = 1'b1;
        tick(1);
        flush_done = 1'b0;
        tick(1);
        chk("stray_done_ack", 32'(flush_ack), 32'h0);
        chk("stray_done_cmd", 32'(cache_flush), 32'h0);

        // Flush and bypass requested together: flush first
        flush_req = 1'b1; bypass_req = 1'b1;
        tick(2);
        chk("both_flush_cmd", 32'(cache_flush), 32'h1);
        chk("both_byp_held", 32'(cache_bypass), 32'h0);
        flush_done = 1'b1;
        tick(1);
        flush_done = 1'b0;
        chk("both_flack", 32'(flush_ack), 32'h1);
        flush_req = 1'b0;
        tick(1);
        chk("both_flack_drop", 32'(flush_ack), 32'h0);
        chk("both_byp_after_fl", 32'(cache_bypass), 32'h0);
        tick(1);
        chk("both_byp_drain", 32'(cache_bypass), 32'h0);
        tick(1);
        chk("both_byp_sel", 32'(cache_bypass), 32'h1);
        tick(1);
        chk("both_byp_ack", 32'(bypass_ack), 32'h1);
        bypass_req = 1'b0;
        tick(3);
        chk("byp_restore", 32'(cache_bypass), 32'h0);

        // Counters, cache in use
        enable_regs = 1'b1; f_trans = 1'b1; f_hit = 1'b1;
        tick(10);
        f_hit = 1'b0; f_miss = 1'b1;
        tick(3);
        f_trans = 1'b0; f_miss = 1'b0;
        tick(1);
        chk("cnt_trans", trans_cnt, 32'd13);
        chk("cnt_hit", hit_cnt, 32'd10);
        chk("cnt_miss", miss_cnt, 32'd3);
        f_hit = 1'b1; f_miss = 1'b1;
        tick(1);
        f_hit = 1'b0; f_miss = 1'b0;
        chk("cnt_both_hit", hit_cnt, 32'd11);
        chk("cnt_both_miss", miss_cnt, 32'd4);
        enable_regs = 1'b0; f_trans = 1'b1; f_hit = 1'b1;
        tick(2);
        f_trans = 1'b0; f_hit = 1'b0;
        chk("cnt_dis_trans", trans_cnt, 32'd13);
        chk("cnt_dis_hit", hit_cnt, 32'd11);
        clear_regs = 1'b1;
        tick(1);
        clear_regs = 1'b0;
        chk("cnt_clear", trans_cnt | hit_cnt | miss_cnt, 32'h0);

        // Counters while bypassed
        bypass_req = 1'b1;
        tick(3);
        chk("cnt_byp_sel", 32'(cache_bypass), 32'h1);
        enable_regs = 1'b1; f_trans = 1'b1; f_hit = 1'b1;
        tick(10);
        f_hit = 1'b0; f_miss = 1'b1;
        tick(3);
        f_trans = 1'b0; f_miss = 1'b0;
        chk("byp_cnt_trans", trans_cnt, 32'd13);
        chk("byp_cnt_hit", hit_cnt, 32'd0);
        chk("byp_cnt_miss", miss_cnt, 32'd0);
        clear_regs = 1'b1; f_trans = 1'b1; f_hit = 1'b1;
        tick(1);
        clear_regs = 1'b0; f_trans = 1'b0; f_hit = 1'b0;
        chk("clear_wins", trans_cnt | hit_cnt | miss_cnt, 32'h0);
        bypass_req = 1'b0;
        tick(3);
        chk("byp_restore2", 32'(cache_bypass), 32'h0);

        // Boundary on 8-bit counters
        clear_regs = 1'b1;
        tick(1);
        clear_regs = 1'b0; f_trans = 1'b1; f_hit = 1'b1;
        tick(254);
        chk("sat_fe", 32'(s_trans), 32'hFE);
        tick(1);
        chk("sat_ff", 32'(s_trans), 32'hFF);
        chk("wrap_ff", 32'(w_trans), 32'hFF);
        tick(1);
        f_trans = 1'b0; f_hit = 1'b0;
        chk("sat_hold_trans", 32'(s_trans), 32'hFF);
        chk("sat_hold_hit", 32'(s_hit), 32'hFF);
        chk("wrap_trans", 32'(w_trans), 32'h00);
        chk("wrap_hit", 32'(w_hit), 32'h00);
        chk("wide_no_wrap", trans_cnt, 32'd256);

        // Async reset during FLUSH_WAIT
        flush_req = 1'b1;
        tick(2);
        chk("rst_fw_cmd", 32'(cache_flush), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk_outs_zero("rst_fw");
        flush_req = 1'b0;
        tick(1);
        rst_n = 1'b1;

        // Async reset during BYP_DRAIN
        bypass_req = 1'b1;
        tick(3);
        chk("rst_bd_pre_ack", 32'(bypass_ack), 32'h1);
        bypass_req = 1'b0; cache_idle = 1'b0;
        tick(2);
        chk("rst_bd_pre_sel", 32'(cache_bypass), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk_outs_zero("rst_bd");
        cache_idle = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // Fresh flush at minimum latency: done one cycle after the command
        flush_req = 1'b1;
        tick(2);
        chk("post_cmd", 32'(cache_flush), 32'h1);
        chk("post_ack0", 32'(flush_ack), 32'h0);
        tick(1);
        chk("post_cmd_off", 32'(cache_flush), 32'h0);
        flush_done = 1'b1;
        tick(1);
        flush_done = 1'b0;
        chk("post_ack", 32'(flush_ack), 32'h1);
        flush_req = 1'b0;
        tick(1);
        chk("post_ack_drop", 32'(flush_ack), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pri_icache_ctrl_slave.md
Name: pri_icache_ctrl_slave

Overview:
- Cache-side endpoint of the private instruction cache control bus; sits between the cluster icache control unit (bus master) and one private icache core.
- Sequences bypass-mode changes and flushes against the cache's idle/flush-done status and returns four-phase acknowledges.
- Maintains the transaction/hit/miss performance counters read back by the control unit.

Parameters:
- CNT_WIDTH, 32, width of each performance counter; must equal the 32-bit bus counter fields.
- SATURATE, 1, 1 = counters stick at all-ones; 0 = counters wrap to zero.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- bypass_req_i  in  1  level request from control unit: 1 = bypass cache, 0 = use cache
- bypass_ack_o  out  1  applied bypass state, valid once the mode switch completes
- flush_req_i  in  1  four-phase flush request
- flush_ack_o  out  1  four-phase flush acknowledge
- ctrl_clear_regs_i  in  1  synchronous clear of all counters
- ctrl_enable_regs_i  in  1  counter enable
- ctrl_hit_count_o  out  CNT_WIDTH  hit counter
- ctrl_trans_count_o  out  CNT_WIDTH  transaction counter
- ctrl_miss_count_o  out  CNT_WIDTH  miss counter
- cache_idle_i  in  1  cache has no outstanding refill or fetch in flight
- cache_bypass_o  out  1  bypass select driven into the cache datapath
- cache_flush_o  out  1  single-cycle flush command to the cache
- cache_flush_done_i  in  1  single-cycle pulse: invalidation finished
- fetch_trans_i  in  1  fetch request accepted this cycle (req & gnt)
- fetch_hit_i  in  1  tag hit this cycle
- fetch_miss_i  in  1  tag miss this cycle

Behaviour:
- Reset (async, rst_ni=0): FSM=IDLE; all counters 0; bypass_ack_o=0, cache_bypass_o=0, flush_ack_o=0, cache_flush_o=0. Reset mid-operation abandons any switch or flush in progress; no ack is issued.
- FSM states: IDLE, BYP_DRAIN, FLUSH_DRAIN, FLUSH_WAIT, FLUSH_ACK.
- IDLE → FLUSH_DRAIN when flush_req_i=1 and flush_ack_o=0. This has priority over a bypass change.
- IDLE → BYP_DRAIN when bypass_req_i != cache_bypass_o and no flush is pending.
- BYP_DRAIN:
  - Wait for cache_idle_i=1.
  - In that cycle register cache_bypass_o <= bypass_req_i as sampled then.
  - Next cycle bypass_ack_o = cache_bypass_o; return to IDLE.
  - If bypass_req_i toggles back while waiting, the switch completes with the value present when idle is seen. A no-op switch is allowed.
- Invariant: bypass_ack_o always equals cache_bypass_o delayed by one cycle. The control unit sees completion when bypass_ack_o == bypass_req_i.
- FLUSH_DRAIN: wait for cache_idle_i=1; pulse cache_flush_o for exactly 1 cycle; go to FLUSH_WAIT.
- FLUSH_WAIT: wait for cache_flush_done_i. A flush_done pulse in any other state is ignored.
- FLUSH_ACK:
  - flush_ack_o=1 (registered) until flush_req_i=0.
  - Then flush_ack_o=0 the next cycle; go to IDLE.
  - A bypass change pending during a flush is served after IDLE is re-entered.
- Minimum flush latency, req to ack, with idle=1 and done returned 1 cycle after the command: 4 cycles.
- Counters: all update on the clock edge.
  - ctrl_clear_regs_i=1: all counters <= 0. Clear wins over increment in the same cycle.
  - Otherwise, if ctrl_enable_regs_i=1:
    - trans += fetch_trans_i.
    - hit += fetch_hit_i & ~cache_bypass_o.
    - miss += fetch_miss_i & ~cache_bypass_o.
  - Hit/miss are not counted while bypassed; trans always is.
  - Hit and miss count independently if both are asserted.
  - At all-ones: SATURATE=1 holds the value; SATURATE=0 wraps to 0.
  - Enable=0 holds the values.
- Counter outputs are direct register outputs; read latency 0 after the update edge.

Test Plan:
- Reset, then bypass_req_i=1 with cache_idle_i=0 for 5 cycles, then 1:
  - cache_bypass_o rises in the idle cycle; bypass_ack_o rises 1 cycle later.
  - Deassert req → both return to 0 by the same rule.
- flush_req_i=1, idle=1, done 2 cycles after cache_flush_o:
  - cache_flush_o high exactly 1 cycle; flush_ack_o=1 until req drops, then 0 next cycle.
  - A stray done in IDLE has no effect.
- flush_req_i and bypass_req_i rise in the same cycle:
  - The flush completes first.
  - The bypass switch happens only after the flush handshake closes; bypass_ack_o=1 afterwards.
- Enable=1 with 10 cycles of trans+hit, then 3 trans+miss:
  - Counts trans=13, hit=10, miss=3.
  - Repeat with cache_bypass_o=1: trans=13, hit=0, miss=0.
  - Clear+enable+trans in the same cycle: all counters 0.
- Counter boundary, SATURATE=1: preload via 2^32-1 events or forced state, then one more trans → stays 0xFFFFFFFF. With SATURATE=0 → 0x00000000.
- Assert rst_ni=0 during FLUSH_WAIT and during BYP_DRAIN:
  - All outputs 0 immediately (async).
  - After release, a fresh flush request runs the full sequence normally.
